// File: rtl/sample_mem_writer_pkg.sv
// Shared capture-path constants: writer FSM state encoding and capture mode values.
package sample_mem_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_CIRCULAR = 1'b1;

endpackage

// File: rtl/sample_decimator.sv
// Modulo-DECIM transfer counter; keep is high for the first of every DECIM transfers.
module sample_decimator
    import sample_mem_writer_pkg::*;
#(
    parameter int DECIM = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic keep
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] cnt_r;

    // Phase counter: cleared at capture start, advanced once per transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign keep = (DECIM == 1) ? 1'b1 : (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sample_mem_writer.sv
// Capture-side sample RAM writer: valid/ready sample stream in, registered RAM write port out,
// with one-shot or circular capture and optional decimation.
module sample_mem_writer
    import sample_mem_writer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DECIM  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              circular,
    input  logic              stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    logic              circ_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              wrap_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic clear_s;
    logic xfer_s;
    logic keep_s;
    logic write_s;
    logic finish_s;

    sample_decimator #(.DECIM(DECIM)) u_decim (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .en    (xfer_s),
        .keep  (keep_s)
    );

    // Transfer qualification and end-of-capture detection
    always_comb begin
        clear_s  = 1'b0;
        xfer_s   = 1'b0;
        write_s  = 1'b0;
        finish_s = 1'b0;
        if (state_r == S_IDLE) begin
            clear_s = start;
        end else if (state_r == S_CAPTURE) begin
            xfer_s  = s_valid;
            write_s = s_valid && keep_s;
            if (circ_r == MODE_CIRCULAR) begin
                finish_s = stop;
            end else begin
                finish_s = write_s && (ptr_r == PTR_LAST);
            end
        end else begin
            clear_s = 1'b0;
        end
    end

    // Capture FSM, write pointer, sample count, wrap flag and RAM write register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            circ_r      <= MODE_ONESHOT;
            ptr_r       <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W + 1){1'b0}};
            wrap_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_CAPTURE;
                        circ_r  <= circular;
                        ptr_r   <= {ADDR_W{1'b0}};
                        count_r <= {(ADDR_W + 1){1'b0}};
                        wrap_r  <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (write_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= ptr_r;
                        mem_wdata_r <= s_data;
                        ptr_r       <= ptr_r + ADDR_W'(1);
                        if (count_r != COUNT_MAX) begin
                            count_r <= count_r + (ADDR_W + 1)'(1);
                        end
                        // Second visit to address 0 marks the first overwrite of old data
                        if ((circ_r == MODE_CIRCULAR) && (ptr_r == {ADDR_W{1'b0}}) &&
                            (count_r == COUNT_MAX)) begin
                            wrap_r <= 1'b1;
                        end
                    end
                    if (finish_s) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = (state_r == S_CAPTURE);
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);
    assign wrap      = wrap_r;
    assign count     = count_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_sample_mem_writer.sv
// Self-checking bench for sample_mem_writer: DECIM=1 and DECIM=3 instances driven from shared
// inputs, compared cycle by cycle against a sample-counting reference model.
module tb_sample_mem_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       circular = 1'b0;
    logic       stop = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;

    logic       s_ready1, mem_we1, busy1, done1, wrap1;
    logic [3:0] mem_addr1;
    logic [7:0] mem_wdata1;
    logic [4:0] count1;
    logic       s_ready3, mem_we3, busy3, done3, wrap3;
    logic [3:0] mem_addr3;
    logic [7:0] mem_wdata3;
    logic [4:0] count3;

    int checks = 0;
    int errors = 0;
    bit sel3 = 1'b0;

    // reference model: capture active, done cycle, accepted and kept sample counts
    bit         m_active, m_in_done, m_circ, m_wrap;
    int         m_acc, m_kept;
    bit         e_we;
    logic [3:0] e_addr;
    logic [7:0] e_wdata;

    logic       o_we, o_done, o_busy, o_ready, o_wrap;
    logic [3:0] o_addr;
    logic [7:0] o_wdata;
    logic [4:0] o_count;

    assign o_we    = sel3 ? mem_we3    : mem_we1;
    assign o_done  = sel3 ? done3      : done1;
    assign o_busy  = sel3 ? busy3      : busy1;
    assign o_ready = sel3 ? s_ready3   : s_ready1;
    assign o_wrap  = sel3 ? wrap3      : wrap1;
    assign o_addr  = sel3 ? mem_addr3  : mem_addr1;
    assign o_wdata = sel3 ? mem_wdata3 : mem_wdata1;
    assign o_count = sel3 ? count3     : count1;

    sample_mem_writer #(.DATA_W(8), .ADDR_W(4), .DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .circular(circular), .stop(stop),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .busy(busy1), .done(done1),
        .wrap(wrap1), .count(count1)
    );

    sample_mem_writer #(.DATA_W(8), .ADDR_W(4), .DECIM(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .circular(circular), .stop(stop),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready3), .mem_we(mem_we3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .busy(busy3), .done(done3),
        .wrap(wrap3), .count(count3)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_active = 1'b0; m_in_done = 1'b0; m_circ = 1'b0; m_wrap = 1'b0;
        m_acc = 0; m_kept = 0; e_we = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; circular = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    // one clock: drive inputs, advance the model, compare every output with it
    task automatic step(input bit st, input bit ci, input bit sp, input bit va, input logic [7:0] d);
        int dec;
        bit fin;
        int e_count;
        dec = sel3 ? 3 : 1;
        start = st; circular = ci; stop = sp; s_valid = va; s_data = d;
        @(posedge clk);
        #1;
        e_we = 1'b0;
        fin = 1'b0;
        if (m_active) begin
            if (va) begin
                if (m_acc % dec == 0) begin
                    e_we = 1'b1;
                    e_addr = 4'(m_kept % 16);
                    e_wdata = d;
                    if (m_circ && m_kept >= 16 && m_kept % 16 == 0) m_wrap = 1'b1;
                    m_kept++;
                    if (!m_circ && m_kept == 16) fin = 1'b1;
                end
                m_acc++;
            end
            if (m_circ && sp) fin = 1'b1;
            if (fin) m_active = 1'b0;
            m_in_done = fin;
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (st) begin
            m_active = 1'b1; m_acc = 0; m_kept = 0; m_circ = ci; m_wrap = 1'b0;
        end
        start = 1'b0; stop = 1'b0;
        e_count = (m_kept > 16) ? 16 : m_kept;
        checks++;
        if (o_we !== e_we) begin errors++; $display("FAIL mem_we: got %b expected %b at %0t", o_we, e_we, $time); end
        if (e_we) begin
            checks++;
            if (o_addr !== e_addr) begin errors++; $display("FAIL mem_addr: got %0d expected %0d at %0t", o_addr, e_addr, $time); end
            checks++;
            if (o_wdata !== e_wdata) begin errors++; $display("FAIL mem_wdata: got %h expected %h at %0t", o_wdata, e_wdata, $time); end
        end
        checks++;
        if (o_done !== m_in_done) begin errors++; $display("FAIL done: got %b expected %b at %0t", o_done, m_in_done, $time); end
        checks++;
        if (o_busy !== (m_active || m_in_done)) begin errors++; $display("FAIL busy: got %b expected %b at %0t", o_busy, m_active || m_in_done, $time); end
        checks++;
        if (o_ready !== m_active) begin errors++; $display("FAIL s_ready: got %b expected %b at %0t", o_ready, m_active, $time); end
        checks++;
        if (o_wrap !== m_wrap) begin errors++; $display("FAIL wrap: got %b expected %b at %0t", o_wrap, m_wrap, $time); end
        checks++;
        if (o_count !== 5'(e_count)) begin errors++; $display("FAIL count: got %0d expected %0d at %0t", o_count, e_count, $time); end
    endtask

    task automatic test_reset();
        sel3 = 1'b0;
        apply_reset();
        checks++;
        if ({s_ready1, mem_we1, busy1, done1, wrap1} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {s_ready1, mem_we1, busy1, done1, wrap1});
        end
        checks++;
        if ({mem_addr1, mem_wdata1, count1} !== 17'd0) begin
            errors++; $display("FAIL reset_values: got addr %0d wdata %h count %0d expected zeros", mem_addr1, mem_wdata1, count1);
        end
    endtask

    task automatic test_oneshot();
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i));
            checks++;
            if (mem_addr1 !== 4'(i) || mem_wdata1 !== 8'(i)) begin
                errors++; $display("FAIL oneshot_write: got addr %0d data %0d expected %0d", mem_addr1, mem_wdata1, i);
            end
        end
        checks++;
        if (done1 !== 1'b1 || count1 !== 5'd16 || wrap1 !== 1'b0 || s_ready1 !== 1'b0) begin
            errors++; $display("FAIL oneshot_end: got done %b count %0d wrap %b ready %b expected 1 16 0 0", done1, count1, wrap1, s_ready1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_circular();
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, i == 19, 1'b1, 8'(i - 10));
            if (i < 15) begin
                checks++;
                if (wrap1 !== 1'b0) begin errors++; $display("FAIL circ_wrap_early: got %b expected 0 at sample %0d", wrap1, i); end
            end
            if (i == 16) begin
                checks++;
                if (wrap1 !== 1'b1 || mem_addr1 !== 4'd0) begin
                    errors++; $display("FAIL circ_wrap: got wrap %b addr %0d expected 1 0", wrap1, mem_addr1);
                end
            end
        end
        checks++;
        if (done1 !== 1'b1 || mem_we1 !== 1'b1 || mem_addr1 !== 4'd3 || mem_wdata1 !== 8'd9 || count1 !== 5'd16) begin
            errors++; $display("FAIL circ_stop: got done %b we %b addr %0d data %0d count %0d expected 1 1 3 9 16",
                done1, mem_we1, mem_addr1, mem_wdata1, count1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_decim();
        int n;
        sel3 = 1'b1;
        apply_reset();
        n = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 48; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i));
            if (mem_we3) begin
                checks++;
                if (mem_addr3 !== 4'(n) || mem_wdata3 !== 8'(3 * n)) begin
                    errors++; $display("FAIL decim_write: got addr %0d data %0d expected %0d %0d", mem_addr3, mem_wdata3, n, 3 * n);
                end
                n++;
            end
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL decim_count: got %0d writes expected 16", n); end
        sel3 = 1'b0;
    endtask

    task automatic test_backpressure();
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, i % 2 == 0, 8'($urandom));
            checks++;
            if (mem_we1 !== (i % 2 == 0)) begin errors++; $display("FAIL bp_we: got %b expected %b", mem_we1, i % 2 == 0); end
        end
        checks++;
        if (count1 !== 5'd5) begin errors++; $display("FAIL bp_count: got %0d expected 5", count1); end
    endtask

    task automatic test_restart_and_stop_ignored();
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        checks++;
        if (mem_addr1 !== 4'd4 || count1 !== 5'd5) begin
            errors++; $display("FAIL restart_ignored: got addr %0d count %0d expected 4 5", mem_addr1, count1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hBB);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || mem_addr1 !== 4'd5) begin
            errors++; $display("FAIL stop_oneshot: got done %b busy %b addr %0d expected 0 1 5", done1, busy1, mem_addr1);
        end
    endtask

    task automatic test_reset_mid();
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 100));
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (mem_we1 !== 1'b0 || count1 !== 5'd0 || s_ready1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got we %b count %0d ready %b busy %b expected 0 0 0 0", mem_we1, count1, s_ready1, busy1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done1 !== 1'b0) begin errors++; $display("FAIL reset_no_done: got %b expected 0", done1); end
        end
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        checks++;
        if (mem_we1 !== 1'b1 || mem_addr1 !== 4'd0) begin
            errors++; $display("FAIL reset_restart: got we %b addr %0d expected 1 0", mem_we1, mem_addr1);
        end
    endtask

    task automatic test_signed();
        logic [7:0] vals [3];
        vals[0] = 8'h80; vals[1] = 8'h7F; vals[2] = 8'hFF;
        sel3 = 1'b0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, vals[i]);
            checks++;
            if (mem_wdata1 !== vals[i]) begin errors++; $display("FAIL signed: got %h expected %h", mem_wdata1, vals[i]); end
        end
    endtask

    task automatic test_random(input bit use3);
        sel3 = use3;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7, 0) == 0, 1'($urandom), $urandom_range(9, 0) == 0,
                 $urandom_range(3, 0) != 0, 8'($urandom));
        end
        sel3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_circular();
        test_decim();
        test_backpressure();
        test_restart_and_stop_ignored();
        test_reset_mid();
        test_signed();
        test_random(1'b0);
        test_random(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
